// File: rtl/firstband_predictor_multimode.sv
// First-band predictor: left/up/average/MED prediction per sample.
// Optional residual output enabled by FIRSTBAND_PREDICTOR_RESIDUAL_EN.
module firstband_predictor_multimode #(
  parameter int DATA_WIDTH         = 16,
  parameter int MAX_SLICE_SIZE_LOG = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x_data,
  input  logic                  x_last_r,
  input  logic                  x_last_s,
  input  logic [1:0]            mode,
  output logic                  xtilde_valid,
  input  logic                  xtilde_ready,
  output logic [DATA_WIDTH-1:0] xtilde_data,
  output logic                  xtilde_last,
  output logic                  err_overrun
`ifdef FIRSTBAND_PREDICTOR_RESIDUAL_EN
  ,
  output logic signed [DATA_WIDTH:0] xres_data
`endif
);

  localparam int DW    = DATA_WIDTH;
  localparam int CW    = MAX_SLICE_SIZE_LOG;
  localparam int DEPTH = 1 << CW;

  logic [DW-1:0] mem [DEPTH];

  logic [CW-1:0] col_q, col_d;
  logic          first_row_q, first_row_d;
  logic          first_smp_q, first_smp_d;
  logic [DW-1:0] left_q, left_d;
  logic [DW-1:0] upleft_q, upleft_d;
  logic [1:0]    mode_q, mode_d;
  logic          err_q, err_d;
  logic          vld_q, vld_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
`ifdef FIRSTBAND_PREDICTOR_RESIDUAL_EN
  logic signed [DW:0] res_q, res_d;
`endif

  logic          acc;
  logic [DW-1:0] up;
  logic [DW:0]   sum1;
  logic [DW+1:0] med_s;
  logic [DW-1:0] mx, mn, med, mode_pred, pred;

  assign x_ready      = !vld_q || xtilde_ready;
  assign acc          = x_valid && x_ready;
  assign xtilde_valid = vld_q;
  assign xtilde_data  = data_q;
  assign xtilde_last  = last_q;
  assign err_overrun  = err_q;
`ifdef FIRSTBAND_PREDICTOR_RESIDUAL_EN
  assign xres_data    = res_q;
`endif

  // Neighbour fetch and prediction for the sample on the input port
  always_comb begin
    up    = mem[col_q];
    sum1  = {1'b0, left_q} + {1'b0, up};
    med_s = {2'b0, left_q} + {2'b0, up} - {2'b0, upleft_q};
    mx    = (left_q >= up) ? left_q : up;
    mn    = (left_q >= up) ? up : left_q;
    if (upleft_q >= mx)      med = mn;
    else if (upleft_q <= mn) med = mx;
    else                     med = med_s[DW-1:0];
    unique case (mode_q)
      2'd0:    mode_pred = left_q;
      2'd1:    mode_pred = up;
      2'd2:    mode_pred = sum1[DW:1];
      default: mode_pred = med;
    endcase
    priority case (1'b1)
      first_smp_q:                    pred = '0;
      first_row_q && col_q != '0:     pred = left_q;
      !first_row_q && col_q == '0:    pred = up;
      default:                        pred = mode_pred;
    endcase
  end

  // Next-state for slice tracking and the output register
  always_comb begin
    col_d       = col_q;
    first_row_d = first_row_q;
    first_smp_d = first_smp_q;
    left_d      = left_q;
    upleft_d    = upleft_q;
    mode_d      = mode_q;
    err_d       = err_q;
    vld_d       = vld_q;
    data_d      = data_q;
    last_d      = last_q;
`ifdef FIRSTBAND_PREDICTOR_RESIDUAL_EN
    res_d       = res_q;
`endif
    if (x_ready) vld_d = x_valid;
    if (acc) begin
      data_d      = pred;
      last_d      = x_last_s;
`ifdef FIRSTBAND_PREDICTOR_RESIDUAL_EN
      res_d       = signed'({1'b0, x_data}) - signed'({1'b0, pred});
`endif
      left_d      = x_data;
      upleft_d    = up;
      col_d       = col_q + 1'b1;
      first_smp_d = 1'b0;
      if (first_smp_q) mode_d = mode;
      if (!x_last_r && col_q == '1) err_d = 1'b1;
      if (x_last_r) begin
        col_d       = '0;
        left_d      = '0;
        upleft_d    = '0;
        first_row_d = 1'b0;
      end
      if (x_last_s) begin
        first_row_d = 1'b1;
        first_smp_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      first_row_q <= 1'b1;
      first_smp_q <= 1'b1;
      left_q      <= '0;
      upleft_q    <= '0;
      mode_q      <= '0;
      err_q       <= 1'b0;
      vld_q       <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
`ifdef FIRSTBAND_PREDICTOR_RESIDUAL_EN
      res_q       <= '0;
`endif
    end else begin
      col_q       <= col_d;
      first_row_q <= first_row_d;
      first_smp_q <= first_smp_d;
      left_q      <= left_d;
      upleft_q    <= upleft_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      vld_q       <= vld_d;
      data_q      <= data_d;
      last_q      <= last_d;
`ifdef FIRSTBAND_PREDICTOR_RESIDUAL_EN
      res_q       <= res_d;
`endif
    end
  end

  // Row buffer: read-before-write, contents never reset
  always_ff @(posedge clk) begin
    if (acc) mem[col_q] <= x_data;
  end

endmodule

// File: tb/tb_firstband_predictor_multimode.sv
// Directed bench for firstband_predictor_multimode.
// Vector table plus stall, overrun and async-reset sequences.
module tb_firstband_predictor_multimode;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_valid, x_ready;
  logic [15:0] x_data;
  logic        x_last_r, x_last_s;
  logic [1:0]  mode;
  logic        xtilde_valid, xtilde_ready;
  logic [15:0] xtilde_data;
  logic        xtilde_last;
  logic        err_overrun;
`ifdef FIRSTBAND_PREDICTOR_RESIDUAL_EN
  logic signed [16:0] xres_data;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  firstband_predictor_multimode #(
    .DATA_WIDTH(16),
    .MAX_SLICE_SIZE_LOG(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .x_data(x_data),
    .x_last_r(x_last_r),
    .x_last_s(x_last_s),
    .mode(mode),
    .xtilde_valid(xtilde_valid),
    .xtilde_ready(xtilde_ready),
    .xtilde_data(xtilde_data),
    .xtilde_last(xtilde_last),
    .err_overrun(err_overrun)
`ifdef FIRSTBAND_PREDICTOR_RESIDUAL_EN
    ,
    .xres_data(xres_data)
`endif
  );

  typedef struct {
    logic        v;
    logic [15:0] x;
    logic        r;
    logic        s;
    logic [1:0]  m;
    logic        rdy;
    logic        exp_xr;
    logic        exp_v;
    logic [15:0] exp_d;
    logic        exp_l;
    logic        exp_e;
    int          exp_res;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic v, input int x, input logic r, input logic s,
    input int m, input logic rdy, input logic exr, input logic ev,
    input int ed, input logic el, input logic ee, input int eres);
    vec_t t;
    t.v = v; t.x = 16'(x); t.r = r; t.s = s; t.m = 2'(m);
    t.rdy = rdy; t.exp_xr = exr; t.exp_v = ev; t.exp_d = 16'(ed);
    t.exp_l = el; t.exp_e = ee; t.exp_res = eres;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send(input int x, input logic r, input logic s,
                      input int m, input int ep, input logic el);
    @(negedge clk);
    x_valid = 1'b1; x_data = 16'(x); x_last_r = r; x_last_s = s;
    mode = 2'(m); xtilde_ready = 1'b1;
    #1 chk("seq_xready", int'(x_ready), 1);
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    chk("seq_valid", int'(xtilde_valid), 1);
    chk("seq_data", int'(xtilde_data), ep);
    chk("seq_last", int'(xtilde_last), int'(el));
  endtask

  initial begin
    // slice A: mode 2
    tv.push_back(mk(1, 10, 0, 0, 2, 1, 1, 1,  0, 0, 0, 10));
    tv.push_back(mk(1, 20, 1, 0, 2, 1, 1, 1, 10, 0, 0, 10));
    tv.push_back(mk(1, 30, 0, 0, 2, 1, 1, 1, 10, 0, 0, 20));
    tv.push_back(mk(1, 40, 1, 1, 2, 1, 1, 1, 25, 1, 0, 15));
    // slice B: mode 0, port mode changes mid-slice
    tv.push_back(mk(1, 10, 0, 0, 0, 1, 1, 1,  0, 0, 0, 10));
    tv.push_back(mk(1, 20, 1, 0, 3, 1, 1, 1, 10, 0, 0, 10));
    tv.push_back(mk(1, 30, 0, 0, 1, 1, 1, 1, 10, 0, 0, 20));
    tv.push_back(mk(1, 40, 1, 1, 2, 1, 1, 1, 30, 1, 0, 10));
    // slice C: mode 1
    tv.push_back(mk(1, 10, 0, 0, 1, 1, 1, 1,  0, 0, 0, 10));
    tv.push_back(mk(1, 20, 1, 0, 0, 1, 1, 1, 10, 0, 0, 10));
    tv.push_back(mk(1, 30, 0, 0, 3, 1, 1, 1, 10, 0, 0, 20));
    tv.push_back(mk(1, 40, 1, 1, 0, 1, 1, 1, 20, 1, 0, 20));
    // slice D: mode 3 (MED)
    tv.push_back(mk(1, 10, 0, 0, 3, 1, 1, 1,  0, 0, 0, 10));
    tv.push_back(mk(1, 20, 1, 0, 2, 1, 1, 1, 10, 0, 0, 10));
    tv.push_back(mk(1, 30, 0, 0, 0, 1, 1, 1, 10, 0, 0, 20));
    tv.push_back(mk(1, 40, 1, 1, 1, 1, 1, 1, 30, 1, 0, 10));
    // slice E: mode 2 with a 5-cycle downstream stall
    tv.push_back(mk(1, 10, 0, 0, 2, 1, 1, 1,  0, 0, 0, 10));
    for (int k = 0; k < 5; k++)
      tv.push_back(mk(1, 20, 1, 0, 2, 0, 0, 1, 0, 0, 0, 10));
    tv.push_back(mk(1, 20, 1, 0, 2, 1, 1, 1, 10, 0, 0, 10));
    tv.push_back(mk(1, 30, 0, 0, 2, 1, 1, 1, 10, 0, 0, 20));
    tv.push_back(mk(1, 40, 1, 1, 2, 1, 1, 1, 25, 1, 0, 15));
    tv.push_back(mk(0,  0, 0, 0, 2, 1, 1, 0,  0, 0, 0, 0));
    // slice F: 5-sample row on a 4-deep buffer, mode 0
    tv.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1));
    tv.push_back(mk(1, 2, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1));
    tv.push_back(mk(1, 3, 0, 0, 0, 1, 1, 1, 2, 0, 0, 1));
    tv.push_back(mk(1, 4, 0, 0, 0, 1, 1, 1, 3, 0, 1, 1));
    tv.push_back(mk(1, 5, 1, 1, 0, 1, 1, 1, 4, 1, 1, 1));
    // slice G: error stays set into next slice
    tv.push_back(mk(1, 10, 0, 0, 2, 1, 1, 1,  0, 0, 1, 10));
    tv.push_back(mk(1, 20, 1, 0, 2, 1, 1, 1, 10, 0, 1, 10));
    tv.push_back(mk(1, 30, 0, 0, 2, 1, 1, 1, 10, 0, 1, 20));
    tv.push_back(mk(1, 40, 1, 1, 2, 1, 1, 1, 25, 1, 1, 15));

    rst = 1'b0; x_valid = 1'b0; x_data = '0; x_last_r = 1'b0;
    x_last_s = 1'b0; mode = '0; xtilde_ready = 1'b1;
    #12;
    chk("rst_valid", int'(xtilde_valid), 0);
    chk("rst_data", int'(xtilde_data), 0);
    chk("rst_last", int'(xtilde_last), 0);
    chk("rst_err", int'(err_overrun), 0);
`ifdef FIRSTBAND_PREDICTOR_RESIDUAL_EN
    chk("rst_res", int'(xres_data), 0);
`endif
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      x_valid = tv[i].v; x_data = tv[i].x; x_last_r = tv[i].r;
      x_last_s = tv[i].s; mode = tv[i].m; xtilde_ready = tv[i].rdy;
      #1 chk($sformatf("v%0d_xready", i), int'(x_ready), int'(tv[i].exp_xr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), int'(xtilde_valid), int'(tv[i].exp_v));
      chk($sformatf("v%0d_err", i), int'(err_overrun), int'(tv[i].exp_e));
      if (tv[i].exp_v) begin
        chk($sformatf("v%0d_data", i), int'(xtilde_data), int'(tv[i].exp_d));
        chk($sformatf("v%0d_last", i), int'(xtilde_last), int'(tv[i].exp_l));
`ifdef FIRSTBAND_PREDICTOR_RESIDUAL_EN
        chk($sformatf("v%0d_res", i), int'(xres_data), tv[i].exp_res);
`endif
      end
    end

    // partial 4-wide slice, then asynchronous reset mid-row
    send(1, 0, 0, 2, 0, 0);
    send(2, 0, 0, 2, 1, 0);
    send(3, 0, 0, 2, 2, 0);
    send(4, 1, 0, 2, 3, 0);
    send(5, 0, 0, 2, 1, 0);
    send(6, 0, 0, 2, 3, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", int'(xtilde_valid), 0);
    chk("arst_err", int'(err_overrun), 0);
    @(negedge clk);
    rst = 1'b1;

    // fresh slice after reset, mode 3
    send(5,  0, 0, 3, 0, 0);
    send(7,  0, 0, 3, 5, 0);
    send(9,  0, 0, 3, 7, 0);
    send(11, 1, 0, 3, 9, 0);
    send(6,  0, 0, 0, 5, 0);
    send(8,  0, 0, 0, 7, 0);
    send(10, 0, 0, 0, 9, 0);
    send(12, 1, 1, 0, 11, 1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
